// File: rtl/ledsw_bank_pkg.sv
// Shared definitions for the LED/switch register bank.
// Holds the bus FSM state type, the default channel count (the status/flag register sits at
// address NCH, one past the last channel) and the synchronizer depth.
package ledsw_bank_pkg;

  // Default number of channels; the status register address equals the channel count.
  localparam int unsigned DefaultNch = 4;
  localparam int unsigned StatusAddr = DefaultNch;

  // Depth of every clock-domain-crossing synchronizer (W, R, SW).
  localparam int unsigned SyncDepth = 2;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWr   = 2'd1,
    StRd   = 2'd2
  } bus_state_e;

endpackage

// File: rtl/ledsw_bank_if.sv
// Strobe/address side of the host bus.
//   W, R : write/read strobes from the host, asynchronous to the bank clock
//   A    : register address, only meaningful while a strobe is stable high
// The shared DATA bus is a tristate net and stays a plain inout port on the bank.
interface ledsw_bank_if #(
  parameter int unsigned AW = 3
) ();
  logic          W;
  logic          R;
  logic [AW-1:0] A;

  modport master (output W, output R, output A);
  modport slave  (input  W, input  R, input  A);
endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer for signals entering the clk domain.
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset, clears both stages
//   d_i    : asynchronous input
//   q_o    : synchronized output (two clk edges of latency)
module sync2 #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/ledsw_bank.sv
// LED/switch register bank behind an asynchronous strobe bus.
//   clk, reset : bank clock, asynchronous active-low reset
//   bus        : host strobes W/R and address A (slave side)
//   DATA       : shared bidirectional data bus, driven only during a read
//   LED        : NCH channels of LED drive, channel i on [i*DW +: DW]
//   SW         : NCH channels of asynchronous switch inputs
//   IRQ        : registered OR of the switch-change flags
// Addresses 0..NCH-1 are channels (write LED, read SW), address NCH is the change-flag
// register (read, write-1-to-clear); higher addresses read 0 and ignore writes.
module ledsw_bank
  import ledsw_bank_pkg::*;
#(
  parameter int unsigned DW  = 8,
  parameter int unsigned NCH = DefaultNch,
  parameter int unsigned AW  = 3
) (
  input  logic              clk,
  input  logic              reset,
  ledsw_bank_if.slave       bus,
  inout  wire  [DW-1:0]     DATA,
  output logic [NCH*DW-1:0] LED,
  input  logic [NCH*DW-1:0] SW,
  output logic              IRQ
);

  logic              w_s, r_s;
  logic [NCH*DW-1:0] sw_s;

  sync2 #(.Width(1)) u_sync_w (.clk_i(clk), .rst_ni(reset), .d_i(bus.W), .q_o(w_s));
  sync2 #(.Width(1)) u_sync_r (.clk_i(clk), .rst_ni(reset), .d_i(bus.R), .q_o(r_s));
  sync2 #(.Width(NCH*DW)) u_sync_sw (.clk_i(clk), .rst_ni(reset), .d_i(SW), .q_o(sw_s));

  bus_state_e        state_q, state_d;
  logic              w_q, r_q;
  logic [AW-1:0]     wr_addr_q, wr_addr_d;
  logic [DW-1:0]     wr_data_q, wr_data_d;
  logic [DW-1:0]     rd_data_q, rd_data_d;
  logic              oe_q, oe_d;
  logic [NCH*DW-1:0] led_q, led_d;
  logic [NCH*DW-1:0] sw_prev_q;
  logic [NCH-1:0]    flag_q, flag_d;
  logic              irq_q;
  // Prime window spans the synchronizer fill so that switch levels present at reset
  // release are taken as the baseline rather than reported as changes.
  logic [SyncDepth:0] prime_q;

  logic          w_rise, r_rise, commit;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_sel;
  logic [NCH-1:0] flag_set, flag_clr;

  assign w_rise  = w_s & ~w_q;
  assign r_rise  = r_s & ~r_q;
  assign rd_addr = bus.A;

  // Read mux, evaluated only at the R_s rise and captured into rd_data_q.
  always_comb begin
    rd_sel = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (32'(rd_addr) == i) rd_sel = sw_s[i*DW +: DW];
    end
    if (32'(rd_addr) == NCH) rd_sel = DW'(flag_q);
  end

  // Bus FSM
  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rd_data_d = rd_data_q;
    oe_d      = oe_q;
    commit    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (w_rise && !r_s) begin
          state_d   = StWr;
          wr_addr_d = bus.A;
          wr_data_d = DATA;
        end else if (r_rise && !w_s) begin
          state_d   = StRd;
          oe_d      = 1'b1;
          rd_data_d = rd_sel;
        end
      end
      StWr: begin
        if (w_s && r_s) begin
          state_d = StIdle;  // illegal overlap: abort without commit
        end else if (!w_s) begin
          state_d = StIdle;
          commit  = 1'b1;
        end else begin
          wr_data_d = DATA;  // keep tracking DATA while W_s is stably high
        end
      end
      StRd: begin
        if (!r_s || w_s) begin
          state_d = StIdle;
          oe_d    = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
        oe_d    = 1'b0;
      end
    endcase
  end

  // LED and change-flag next state
  always_comb begin
    led_d    = led_q;
    flag_set = '0;
    flag_clr = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (commit && 32'(wr_addr_q) == i) led_d[i*DW +: DW] = wr_data_q;
      if (!prime_q[0] && sw_s[i*DW +: DW] != sw_prev_q[i*DW +: DW]) flag_set[i] = 1'b1;
    end
    if (commit && 32'(wr_addr_q) == NCH) flag_clr = wr_data_q[NCH-1:0];
    flag_d = (flag_q & ~flag_clr) | flag_set;  // set wins over a coincident clear
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      w_q       <= 1'b0;
      r_q       <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_data_q <= '0;
      oe_q      <= 1'b0;
      led_q     <= '0;
      sw_prev_q <= '0;
      flag_q    <= '0;
      irq_q     <= 1'b0;
      prime_q   <= '1;
    end else begin
      state_q   <= state_d;
      w_q       <= w_s;
      r_q       <= r_s;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rd_data_q <= rd_data_d;
      oe_q      <= oe_d;
      led_q     <= led_d;
      sw_prev_q <= sw_s;
      flag_q    <= flag_d;
      irq_q     <= |flag_q;
      prime_q   <= prime_q >> 1;
    end
  end

  assign DATA = oe_q ? rd_data_q : {DW{1'bz}};
  assign LED  = led_q;
  assign IRQ  = irq_q;

endmodule

// File: tb/tb_ledsw_bank.sv
module tb_ledsw_bank;

  localparam int unsigned DW  = 8;
  localparam int unsigned NCH = 4;
  localparam int unsigned AW  = 3;

  logic              clk;
  logic              reset;
  wire  [DW-1:0]     data_bus;
  logic [DW-1:0]     tb_data;
  logic              tb_oe;
  logic [NCH*DW-1:0] LED;
  logic [NCH*DW-1:0] SW;
  logic              IRQ;

  ledsw_bank_if #(.AW(AW)) bus ();

  assign data_bus = tb_oe ? tb_data : {DW{1'bz}};

  ledsw_bank #(.DW(DW), .NCH(NCH), .AW(AW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus),
    .DATA (data_bus),
    .LED  (LED),
    .SW   (SW),
    .IRQ  (IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb_q[$];

  // Bench-side model of the register file.
  logic [DW-1:0]  led_m [NCH];
  logic [NCH-1:0] flag_m;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] got);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL sb_empty: got %h with no expected entry", got);
    end else begin
      e = sb_q.pop_front();
      check_eq(e.tag, got, e.val);
    end
  endtask

  function automatic logic [31:0] led_vec();
    return {led_m[3], led_m[2], led_m[1], led_m[0]};
  endfunction

  function automatic logic [DW-1:0] rd_model(input int unsigned addr);
    if (addr < NCH) return SW[addr*DW +: DW];
    if (addr == NCH) return {{(DW-NCH){1'b0}}, flag_m};
    return '0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) led_m[i] = '0;
    flag_m = '0;
  endtask

  task automatic do_read(input int unsigned addr, input string tag);
    @(negedge clk);
    bus.A = AW'(addr);
    bus.R = 1'b1;
    push_exp(tag, 32'(rd_model(addr)));
    repeat (4) @(posedge clk);
    #1 pop_check(32'(data_bus));
    @(negedge clk);
    bus.R = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_eq({tag, "_release"}, 32'(dut.oe_q), 32'd0);
  endtask

  // Full write cycle; toggle0 flips SW channel 0 at the same instant W falls, which lands the
  // flag set on the same clk edge as the commit.
  task automatic do_write(input int unsigned addr, input logic [DW-1:0] data, input string tag,
                          input bit toggle0);
    if (addr < NCH) led_m[addr] = data;
    if (addr == NCH) flag_m = flag_m & ~data[NCH-1:0];
    if (toggle0) flag_m[0] = 1'b1;
    push_exp({tag, "_led"}, led_vec());
    push_exp({tag, "_irq"}, 32'(|flag_m));
    @(negedge clk);
    bus.A   = AW'(addr);
    tb_data = data;
    tb_oe   = 1'b1;
    bus.W   = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    bus.W = 1'b0;
    if (toggle0) SW[7:0] = SW[7:0] ^ 8'h01;
    repeat (4) @(posedge clk);
    #1 pop_check(32'(LED));
    pop_check(32'(IRQ));
    tb_oe = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    reset   = 1'b0;
    bus.W   = 1'b0;
    bus.R   = 1'b0;
    bus.A   = '0;
    tb_data = '0;
    tb_oe   = 1'b0;
    SW      = {8'h00, 8'h33, 8'h22, 8'h11};
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_eq("rst_led", 32'(LED), 32'd0);
    check_eq("rst_irq", 32'(IRQ), 32'd0);
    check_eq("rst_oe", 32'(dut.oe_q), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (8) @(posedge clk);
    // Nonzero switches at reset release must not raise flags.
    #1 check_eq("prime_irq", 32'(IRQ), 32'd0);

    do_read(1, "rd_ch1");
    do_read(NCH, "rd_flags0");
    do_read(6, "rd_hi_addr");
    check_eq("led_after_rd", 32'(LED), 32'd0);

    do_write(2, 8'hA5, "wr_ch2", 1'b0);
    do_write(0, 8'h3C, "wr_ch0", 1'b0);
    do_write(5, 8'hFF, "wr_hi_addr", 1'b0);
    do_read(2, "rd_ch2_sw");

    // Switch change on channel 3 raises flag 3 and IRQ.
    @(negedge clk);
    SW[31:24] = 8'h10;
    flag_m[3] = 1'b1;
    repeat (4) @(posedge clk);
    #1 check_eq("irq_set", 32'(IRQ), 32'(|flag_m));
    do_read(NCH, "rd_flag3");
    do_read(NCH, "rd_flag3_again");
    do_write(NCH, 8'h08, "w1c_3", 1'b0);
    do_read(NCH, "rd_flags_clr");

    // Set wins over a coincident W1C.
    @(negedge clk);
    SW[7:0] = SW[7:0] ^ 8'h01;
    flag_m[0] = 1'b1;
    repeat (5) @(posedge clk);
    do_write(NCH, 8'h01, "w1c_vs_set", 1'b1);
    do_read(NCH, "rd_flag0_kept");
    do_write(NCH, 8'h01, "w1c_0", 1'b0);

    // W and R together: no transaction, bus never driven.
    @(negedge clk);
    bus.A   = '0;
    tb_data = 8'h77;
    tb_oe   = 1'b1;
    bus.W   = 1'b1;
    bus.R   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1 check_eq("both_oe", 32'(dut.oe_q), 32'd0);
    end
    @(negedge clk);
    bus.W = 1'b0;
    bus.R = 1'b0;
    repeat (4) @(posedge clk);
    #1 check_eq("both_led", 32'(LED), led_vec());
    tb_oe = 1'b0;

    // Reset in the middle of a write.
    @(negedge clk);
    bus.A   = '0;
    tb_data = 8'hFF;
    tb_oe   = 1'b1;
    bus.W   = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    bus.W = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    tb_oe = 1'b0;
    repeat (8) @(posedge clk);
    #1 check_eq("rst_wr_led", 32'(LED), led_vec());
    check_eq("rst_wr_irq", 32'(IRQ), 32'(|flag_m));

    // Reset in the middle of a read releases the bus at once.
    @(negedge clk);
    bus.A = AW'(1);
    bus.R = 1'b1;
    push_exp("rd_mid", 32'(rd_model(1)));
    repeat (4) @(posedge clk);
    #1 pop_check(32'(data_bus));
    check_eq("rd_mid_oe", 32'(dut.oe_q), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    #1 check_eq("rst_rd_oe", 32'(dut.oe_q), 32'd0);
    bus.R = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1 check_eq("rst_rd_led", 32'(LED), 32'd0);

    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: got %0d entries expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard time bound so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
